tlul_reg_adapter: RTL and testbench
===================================

TLUL_REG_ADAPTER -- requirements
Module: tlul_reg_adapter

Interface
REQ-001 SHALL have parameter AW, default 20: register-offset width taken from a_address[AW-1:0], below the mux select bits [23:20].
REQ-002 SHALL have parameter LAT, default 1, range 0..3: clock cycles from register strobe to a valid rdata_i/error_i.
REQ-003 SHALL have port clk_i, input, 1: single clock; all logic is rising-edge.
REQ-004 SHALL have port rst_i, input, 1: asynchronous, active-high reset.
REQ-005 SHALL have port tl_i, input, tlul_pkg::tl_h2d_t: TL-UL A channel plus d_ready, driven by one tl_device_i slot of the TL-UL mux.
REQ-006 SHALL have port tl_o, output, tlul_pkg::tl_d2h_t: TL-UL D channel plus a_ready, returned to the matching mux slot.
REQ-007 SHALL have port re_o, output, 1: register read strobe, one cycle.
REQ-008 SHALL have port we_o, output, 1: register write strobe, one cycle.
REQ-009 SHALL have port addr_o, output, AW: word-aligned offset, with bits [1:0] forced to 0.
REQ-010 SHALL have port wdata_o, output, 32: write data.
REQ-011 SHALL have port be_o, output, 4: byte enables, equal to a_mask.
REQ-012 SHALL have port rdata_i, input, 32: read data, sampled LAT cycles after re_o.
REQ-013 SHALL have port error_i, input, 1: register-side error, sampled with rdata_i.

Function
REQ-014 SHALL implement FSM IDLE -> WAIT -> RESP -> IDLE, with at most one transaction outstanding.
REQ-015 SHALL drive a_ready=1 only in IDLE; the A beat is accepted on a_valid && a_ready.
REQ-016 SHALL, on acceptance, register a_opcode, a_source, a_size, the offset, the mask and the data.
REQ-017 SHALL, in the cycle after acceptance, pulse re_o for Get or we_o for PutFullData/PutPartialData, unless the request is rejected.
REQ-018 SHALL reject a request when: the opcode is not Get, PutFullData or PutPartialData; a_size > 2; a_address is misaligned to a_size; or PutFullData has a mask other than 4'hF.
REQ-019 SHALL, for a rejected request, pulse no strobe and respond with d_error=1, without waiting for LAT.
REQ-020 SHALL stay in WAIT for LAT cycles after the strobe using a 2-bit down-counter; LAT=0 samples rdata_i in the strobe cycle.
REQ-021 SHALL capture rdata_i and error_i into the response register at the end of WAIT.
REQ-022 SHALL, in RESP, hold d_valid=1 and all D fields stable until d_valid && d_ready, then return to IDLE.
REQ-023 SHALL set d_opcode to AccessAckData for Get and AccessAck otherwise, with d_source and d_size echoing the request.
REQ-024 SHALL set d_data to the captured read data for a successful Get, and to 0 for writes and errors.
REQ-025 SHALL set d_error = captured error_i OR the rejection flag.
REQ-026 SHALL, when d_ready is high in the first RESP cycle, complete in that cycle; the earliest next acceptance is the following cycle, giving minimum throughput of one transaction per LAT+3 cycles.
REQ-027 SHALL ignore a_valid while not in IDLE; requests are not queued.
REQ-028 SHALL drive d_valid=0 outside RESP; the mux relies on this to keep its d_valid priority scan quiet.

Reset
REQ-029 SHALL, on rst_i, enter IDLE asynchronously.
REQ-030 SHALL, during reset, drive d_valid=0, a_ready=0, re_o=0 and we_o=0, and clear all captured registers to 0.
REQ-031 SHALL raise a_ready in the first clock edge after rst_i deasserts.
REQ-032 SHALL, on reset in WAIT or RESP, abandon the transaction and emit no response.

Structure
REQ-033 SHALL take the opcode enums (Get, PutFullData, PutPartialData, AccessAck, AccessAckData) and the channel structs from tlul_pkg.
REQ-034 SHALL add no new package content other than the local FSM enum.
REQ-035 SHALL place the request check of REQ-018 in one combinational sub-module, tlul_req_check, which reports an error flag.

Verification
REQ-036 SHALL cover: Get to 0x004 with LAT=1 and rdata_i=0xDEADBEEF -> re_o one cycle later, then d_valid with AccessAckData, d_data=0xDEADBEEF, d_error=0 and source echoed.
REQ-037 SHALL cover: PutPartialData to 0x008 with mask 4'b0011 and data 0x1234 -> we_o, be_o=0011, wdata_o=0x1234, then AccessAck with d_data=0.
REQ-038 SHALL cover: PutFullData with mask 4'b0111, and Get with a_address=0x002 and a_size=2 -> no strobe, and each returns d_error=1.
REQ-039 SHALL cover: d_ready held low for 5 cycles in RESP -> D fields stable, a_ready=0 and a second a_valid ignored; the response completes when d_ready rises.
REQ-040 SHALL cover: rst_i asserted in WAIT -> d_valid never asserts and a_ready=1 after release; LAT=0 and LAT=3 each give correct read data.

Source files
------------

// File: rtl/tlul_pkg.sv
// TL-UL channel types and opcodes shared by the mux and its device adapters.
//   tl_h2d_t : A channel plus d_ready (host to device)
//   tl_d2h_t : D channel plus a_ready (device to host)
package tlul_pkg;

  typedef enum logic [2:0] {
    PutFullData    = 3'h0,
    PutPartialData = 3'h1,
    Get            = 3'h4
  } tl_a_op_e;

  typedef enum logic [2:0] {
    AccessAck     = 3'h0,
    AccessAckData = 3'h1
  } tl_d_op_e;

  typedef struct packed {
    logic        a_valid;
    tl_a_op_e    a_opcode;
    logic [2:0]  a_param;
    logic [1:0]  a_size;
    logic [7:0]  a_source;
    logic [31:0] a_address;
    logic [3:0]  a_mask;
    logic [31:0] a_data;
    logic        d_ready;
  } tl_h2d_t;

  typedef struct packed {
    logic        d_valid;
    tl_d_op_e    d_opcode;
    logic [2:0]  d_param;
    logic [1:0]  d_size;
    logic [7:0]  d_source;
    logic        d_sink;
    logic [31:0] d_data;
    logic        d_error;
    logic        a_ready;
  } tl_d2h_t;

endpackage

// File: rtl/tlul_reg_adapter_pkg.sv
// Local FSM state encoding for tlul_reg_adapter.
package tlul_reg_adapter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_RESP = 2'd2
  } adapter_state_e;

endpackage

// File: rtl/tlul_reg_adapter_req_check.sv
// tlul_req_check: combinational legality check of a TL-UL A beat.
//   i_opcode   : a_opcode
//   i_size     : a_size (log2 bytes)
//   i_addr_lsb : a_address[1:0]
//   i_mask     : a_mask
//   o_err_c    : 1 when the request must be rejected
module tlul_req_check
  import tlul_pkg::*;
(
  input  tl_a_op_e   i_opcode,
  input  logic [1:0] i_size,
  input  logic [1:0] i_addr_lsb,
  input  logic [3:0] i_mask,
  output logic       o_err_c
);

  logic w_op_ok;
  logic w_size_bad;
  logic w_misalign;
  logic w_full_mask_bad;

  assign w_op_ok = (i_opcode == Get) || (i_opcode == PutFullData) ||
                   (i_opcode == PutPartialData);
  // Only 2'd3 (8 bytes) exceeds the 32-bit data path.
  assign w_size_bad = (i_size == 2'd3);
  assign w_misalign = ((i_size == 2'd1) && i_addr_lsb[0]) ||
                      ((i_size == 2'd2) && (i_addr_lsb != 2'b00));
  assign w_full_mask_bad = (i_opcode == PutFullData) && (i_mask != 4'hF);

  assign o_err_c = !w_op_ok || w_size_bad || w_misalign || w_full_mask_bad;

endmodule

// File: rtl/tlul_reg_adapter.sv
// tlul_reg_adapter: bridges one TL-UL device slot to a simple register port.
// One transaction outstanding; rejected requests are answered immediately.
//   clk_i, rst_i  : clock, async active-high reset
//   tl_i / tl_o   : TL-UL A channel in / D channel out
//   re_o, we_o    : one-cycle read / write strobes
//   addr_o        : word-aligned register offset
//   wdata_o, be_o : write data and byte enables
//   rdata_i       : read data, valid LAT cycles after the strobe
//   error_i       : register-side error, sampled with rdata_i
module tlul_reg_adapter
  import tlul_pkg::*;
  import tlul_reg_adapter_pkg::*;
#(
  parameter int unsigned AW  = 20,
  parameter int unsigned LAT = 1
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  tl_h2d_t       tl_i,
  output tl_d2h_t       tl_o,
  output logic          re_o,
  output logic          we_o,
  output logic [AW-1:0] addr_o,
  output logic [31:0]   wdata_o,
  output logic [3:0]    be_o,
  input  logic [31:0]   rdata_i,
  input  logic          error_i
);

  adapter_state_e r_state;
  logic [1:0]     r_cnt;
  tl_a_op_e       r_op;
  logic [7:0]     r_src;
  logic [1:0]     r_size;
  logic [AW-3:0]  r_addr;
  logic [3:0]     r_be;
  logic [31:0]    r_wdata;
  logic           r_rej;
  logic           r_err;
  logic [31:0]    r_rdata;
  logic           r_re;
  logic           r_we;
  logic           r_a_ready;
  logic           r_d_valid;

  logic           w_req_err;
  logic           w_unused;

  // Address bits above the offset are mux select bits; a_param is unused.
  assign w_unused = ^{tl_i.a_param, tl_i.a_address[31:AW]};

  tlul_req_check u_req_check (
    .i_opcode   (tl_i.a_opcode),
    .i_size     (tl_i.a_size),
    .i_addr_lsb (tl_i.a_address[1:0]),
    .i_mask     (tl_i.a_mask),
    .o_err_c    (w_req_err)
  );

  // Request/response FSM; every output below is a register.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_state   <= ST_IDLE;
      r_cnt     <= 2'd0;
      r_op      <= PutFullData;
      r_src     <= 8'd0;
      r_size    <= 2'd0;
      r_addr    <= '0;
      r_be      <= 4'd0;
      r_wdata   <= 32'd0;
      r_rej     <= 1'b0;
      r_err     <= 1'b0;
      r_rdata   <= 32'd0;
      r_re      <= 1'b0;
      r_we      <= 1'b0;
      r_a_ready <= 1'b0;
      r_d_valid <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          r_re <= 1'b0;
          r_we <= 1'b0;
          if (tl_i.a_valid && r_a_ready) begin
            r_a_ready <= 1'b0;
            r_op      <= tl_i.a_opcode;
            r_src     <= tl_i.a_source;
            r_size    <= tl_i.a_size;
            r_addr    <= tl_i.a_address[AW-1:2];
            r_be      <= tl_i.a_mask;
            r_wdata   <= tl_i.a_data;
            r_rej     <= w_req_err;
            r_err     <= 1'b0;
            r_rdata   <= 32'd0;
            r_cnt     <= 2'(LAT);
            if (w_req_err) begin
              // Rejected: skip the register access and respond next cycle.
              r_state   <= ST_RESP;
              r_d_valid <= 1'b1;
            end else begin
              r_state <= ST_WAIT;
              r_re    <= (tl_i.a_opcode == Get);
              r_we    <= (tl_i.a_opcode != Get);
            end
          end else begin
            r_a_ready <= 1'b1;
          end
        end
        ST_WAIT: begin
          r_re <= 1'b0;
          r_we <= 1'b0;
          // First WAIT cycle is the strobe cycle; count LAT more after it.
          if (r_cnt == 2'd0) begin
            r_rdata   <= ((r_op == Get) && !error_i) ? rdata_i : 32'd0;
            r_err     <= error_i;
            r_d_valid <= 1'b1;
            r_state   <= ST_RESP;
          end else begin
            r_cnt <= r_cnt - 2'd1;
          end
        end
        ST_RESP: begin
          if (tl_i.d_ready) begin
            r_d_valid <= 1'b0;
            r_a_ready <= 1'b1;
            r_state   <= ST_IDLE;
          end
        end
        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  assign re_o    = r_re;
  assign we_o    = r_we;
  assign addr_o  = {r_addr, 2'b00};
  assign wdata_o = r_wdata;
  assign be_o    = r_be;

  // D channel assembled from held registers; stable for the whole RESP.
  always_comb begin
    tl_o          = '0;
    tl_o.d_valid  = r_d_valid;
    tl_o.d_opcode = (r_op == Get) ? AccessAckData : AccessAck;
    tl_o.d_size   = r_size;
    tl_o.d_source = r_src;
    tl_o.d_data   = r_rdata;
    tl_o.d_error  = r_err | r_rej;
    tl_o.a_ready  = r_a_ready;
  end

endmodule

// File: tb/tb_tlul_reg_adapter.sv
// Scoreboard bench for tlul_reg_adapter at LAT=1, LAT=0 and LAT=3.
module tb_tlul_reg_adapter;
  import tlul_pkg::*;

  localparam int unsigned AW = 20;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  tl_h2d_t       h2d   [3];
  tl_d2h_t       d2h   [3];
  logic          re    [3];
  logic          we    [3];
  logic [AW-1:0] addr  [3];
  logic [31:0]   wdata [3];
  logic [3:0]    be    [3];
  logic [31:0]   rdata [3];
  logic          err   [3];
  logic          win   [3];
  logic [3:0]    stb_sh[3] = '{default: 4'd0};

  logic [31:0] rd_val;
  logic        err_val;

  tlul_reg_adapter #(.AW(AW), .LAT(1)) u_dut_l1 (
    .clk_i(clk), .rst_i(rst), .tl_i(h2d[0]), .tl_o(d2h[0]), .re_o(re[0]), .we_o(we[0]),
    .addr_o(addr[0]), .wdata_o(wdata[0]), .be_o(be[0]), .rdata_i(rdata[0]), .error_i(err[0]));
  tlul_reg_adapter #(.AW(AW), .LAT(0)) u_dut_l0 (
    .clk_i(clk), .rst_i(rst), .tl_i(h2d[1]), .tl_o(d2h[1]), .re_o(re[1]), .we_o(we[1]),
    .addr_o(addr[1]), .wdata_o(wdata[1]), .be_o(be[1]), .rdata_i(rdata[1]), .error_i(err[1]));
  tlul_reg_adapter #(.AW(AW), .LAT(3)) u_dut_l3 (
    .clk_i(clk), .rst_i(rst), .tl_i(h2d[2]), .tl_o(d2h[2]), .re_o(re[2]), .we_o(we[2]),
    .addr_o(addr[2]), .wdata_o(wdata[2]), .be_o(be[2]), .rdata_i(rdata[2]), .error_i(err[2]));

  // Register model: data/error are valid only exactly LAT cycles after a strobe.
  always @(posedge clk) begin
    for (int k = 0; k < 3; k++) stb_sh[k] <= {stb_sh[k][2:0], re[k] | we[k]};
  end

  always_comb begin
    win[0] = stb_sh[0][0];
    win[1] = re[1] | we[1];
    win[2] = stb_sh[2][2];
    for (int k = 0; k < 3; k++) begin
      rdata[k] = win[k] ? rd_val : 32'hBAD0_BAD0;
      err[k]   = win[k] ? err_val : 1'b1;
    end
  end

  typedef struct {
    logic [2:0]  op;
    logic [7:0]  src;
    logic [1:0]  size;
    logic [31:0] data;
    logic        err;
  } exp_t;

  exp_t sb[$];
  int   vectors    = 0;
  int   miscompares = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic int lat_of(input int k);
    return (k == 0) ? 1 : ((k == 1) ? 0 : 3);
  endfunction

  // One complete transaction on instance k; rej is the bench's own legality verdict.
  task automatic do_txn(input int k, input logic [2:0] op, input logic [31:0] a,
                        input logic [1:0] sz, input logic [3:0] m, input logic [31:0] d,
                        input logic [7:0] src, input bit rej, input int hold);
    exp_t    e;
    exp_t    g;
    bit      is_get;
    int      n;
    tl_d2h_t snap;
    is_get = (op == 3'h4);
    e.op   = is_get ? 3'h1 : 3'h0;
    e.src  = src;
    e.size = sz;
    e.data = (!rej && is_get && !err_val) ? rd_val : 32'd0;
    e.err  = rej | err_val;
    sb.push_back(e);

    check("a_ready_idle", 64'(d2h[k].a_ready), 64'(1));
    h2d[k].a_valid   = 1'b1;
    h2d[k].a_opcode  = tl_a_op_e'(op);
    h2d[k].a_address = a;
    h2d[k].a_size    = sz;
    h2d[k].a_mask    = m;
    h2d[k].a_data    = d;
    h2d[k].a_source  = src;
    h2d[k].d_ready   = (hold == 0);
    tick();
    h2d[k].a_valid = 1'b0;

    check("re_strobe", 64'(re[k]), 64'(!rej && is_get));
    check("we_strobe", 64'(we[k]), 64'(!rej && !is_get));
    if (!rej && !is_get) begin
      check("be_o", 64'(be[k]), 64'(m));
      check("wdata_o", 64'(wdata[k]), 64'(d));
    end
    if (!rej) check("addr_o", 64'(addr[k]), 64'({a[AW-1:2], 2'b00}));
    check("a_ready_busy", 64'(d2h[k].a_ready), 64'(0));

    n = 0;
    while (!d2h[k].d_valid && n < 10) begin
      tick();
      n++;
      check("strobe_once", 64'(re[k] | we[k]), 64'(0));
    end
    check("resp_latency", 64'(n), rej ? 64'(0) : 64'(lat_of(k) + 1));

    if (hold > 0) begin
      snap = d2h[k];
      h2d[k].a_valid  = 1'b1;
      h2d[k].a_opcode = Get;
      h2d[k].a_size   = 2'd2;
      h2d[k].a_mask   = 4'hF;
      for (int i = 0; i < hold; i++) begin
        tick();
        check("hold_stable", 64'(d2h[k]), 64'(snap));
        check("hold_a_ready", 64'(d2h[k].a_ready), 64'(0));
        check("hold_no_strobe", 64'(re[k] | we[k]), 64'(0));
      end
      h2d[k].a_valid = 1'b0;
      h2d[k].d_ready = 1'b1;
    end

    check("d_valid", 64'(d2h[k].d_valid), 64'(1));
    if (sb.size() > 0) begin
      g = sb.pop_front();
      check("d_opcode", 64'(d2h[k].d_opcode), 64'(g.op));
      check("d_source", 64'(d2h[k].d_source), 64'(g.src));
      check("d_size", 64'(d2h[k].d_size), 64'(g.size));
      check("d_data", 64'(d2h[k].d_data), 64'(g.data));
      check("d_error", 64'(d2h[k].d_error), 64'(g.err));
    end
    tick();
    check("d_valid_done", 64'(d2h[k].d_valid), 64'(0));
    check("a_ready_done", 64'(d2h[k].a_ready), 64'(1));
  endtask

  initial begin
    rd_val  = 32'd0;
    err_val = 1'b0;
    for (int k = 0; k < 3; k++) begin
      h2d[k] = '0;
      h2d[k].d_ready = 1'b1;
    end

    repeat (3) tick();
    for (int k = 0; k < 3; k++) begin
      check("rst_d_valid", 64'(d2h[k].d_valid), 64'(0));
      check("rst_a_ready", 64'(d2h[k].a_ready), 64'(0));
      check("rst_re", 64'(re[k]), 64'(0));
      check("rst_we", 64'(we[k]), 64'(0));
      check("rst_d_data", 64'(d2h[k].d_data), 64'(0));
      check("rst_addr", 64'(addr[k]), 64'(0));
    end
    rst = 1'b0;
    tick();
    for (int k = 0; k < 3; k++) check("a_ready_post_rst", 64'(d2h[k].a_ready), 64'(1));

    // LAT=1 instance
    rd_val = 32'hDEAD_BEEF;
    do_txn(0, 3'h4, 32'h0000_0004, 2'd2, 4'hF, 32'h0,         8'h11, 1'b0, 0);
    do_txn(0, 3'h1, 32'h0000_0008, 2'd2, 4'h3, 32'h0000_1234, 8'h22, 1'b0, 0);
    do_txn(0, 3'h0, 32'h0000_000C, 2'd2, 4'h7, 32'h0000_FFFF, 8'h33, 1'b1, 0);
    do_txn(0, 3'h4, 32'h0000_0002, 2'd2, 4'hF, 32'h0,         8'h44, 1'b1, 0);
    rd_val = 32'hCAFE_F00D;
    do_txn(0, 3'h4, 32'h0000_0010, 2'd2, 4'hF, 32'h0,         8'h55, 1'b0, 5);
    do_txn(0, 3'h2, 32'h0000_0000, 2'd2, 4'hF, 32'h0,         8'h66, 1'b1, 0);
    do_txn(0, 3'h4, 32'h0000_0000, 2'd3, 4'hF, 32'h0,         8'h67, 1'b1, 0);
    do_txn(0, 3'h4, 32'h0000_0001, 2'd1, 4'h3, 32'h0,         8'h68, 1'b1, 0);
    do_txn(0, 3'h0, 32'hF001_4014, 2'd2, 4'hF, 32'hA5A5_A5A5, 8'h77, 1'b0, 0);
    do_txn(0, 3'h4, 32'h0000_0006, 2'd1, 4'hC, 32'h0,         8'h88, 1'b0, 0);
    err_val = 1'b1;
    do_txn(0, 3'h4, 32'h0000_0018, 2'd2, 4'hF, 32'h0,         8'h99, 1'b0, 0);
    do_txn(0, 3'h1, 32'h0000_001C, 2'd0, 4'h1, 32'h0000_00AB, 8'h9A, 1'b0, 0);
    err_val = 1'b0;

    // LAT=0 instance
    rd_val = 32'h0BAD_F00D;
    do_txn(1, 3'h4, 32'h0000_0020, 2'd2, 4'hF, 32'h0,         8'h01, 1'b0, 0);
    do_txn(1, 3'h0, 32'h0000_0024, 2'd2, 4'hF, 32'h1111_2222, 8'h02, 1'b0, 0);

    // LAT=3 instance
    rd_val = 32'h1357_9BDF;
    do_txn(2, 3'h4, 32'h0000_0030, 2'd2, 4'hF, 32'h0,         8'h03, 1'b0, 2);

    // Reset while the LAT=3 instance is in WAIT: transaction is dropped.
    h2d[2].a_valid   = 1'b1;
    h2d[2].a_opcode  = Get;
    h2d[2].a_address = 32'h0000_0034;
    h2d[2].a_size    = 2'd2;
    h2d[2].a_mask    = 4'hF;
    tick();
    h2d[2].a_valid = 1'b0;
    check("rst_wait_re", 64'(re[2]), 64'(1));
    tick();
    rst = 1'b1;
    #1;
    check("rst_wait_d_valid", 64'(d2h[2].d_valid), 64'(0));
    check("rst_wait_a_ready", 64'(d2h[2].a_ready), 64'(0));
    check("rst_wait_re_clr", 64'(re[2]), 64'(0));
    tick();
    tick();
    rst = 1'b0;
    for (int i = 0; i < 8; i++) begin
      tick();
      check("rst_wait_no_resp", 64'(d2h[2].d_valid), 64'(0));
      check("rst_wait_a_ready_up", 64'(d2h[2].a_ready), 64'(1));
    end

    rd_val = 32'h2468_ACE0;
    do_txn(2, 3'h4, 32'h0000_0038, 2'd2, 4'hF, 32'h0,         8'h04, 1'b0, 0);

    check("sb_empty", 64'(sb.size()), 64'(0));
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
